// File: rtl/line_delay_ctrl.sv
// line_delay_ctrl: streaming front end for a single line buffer.
// Each accepted pixel is written to the buffer at its column while the
// pixel previously stored there (the row above) is read back. One cycle
// later the vertical pair is presented with its row/column tags.
module line_delay_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ROW_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sof,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_cur,
  output logic [DATA_WIDTH-1:0] out_above,
  output logic [ADDR_WIDTH-1:0] out_col,
  output logic [ROW_WIDTH-1:0]  out_row,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  err_sof
);

  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_LAST = ROW_WIDTH'(IMG_HEIGHT - 1);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] col, col_nxt, pos_col;
  logic [ROW_WIDTH-1:0]  row, row_nxt, pos_row;
  logic                  accept, process, pos_eol, pos_eof, sof_err;

  // Output stage registers (one-deep skid-free stage)
  logic                  vld_p1, top_p1, eol_p1, eof_p1, err_p1;
  logic [DATA_WIDTH-1:0] cur_p1;
  logic [ADDR_WIDTH-1:0] col_p1;
  logic [ROW_WIDTH-1:0]  row_p1;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state logic: decide whether the pixel is processed, where it lands, and advance position
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    process   = 1'b0;
    sof_err   = 1'b0;
    pos_col   = col;
    pos_row   = row;
    // A start-of-frame pixel is always placed at the origin, legal or not.
    if (in_sof) begin
      pos_col = '0;
      pos_row = '0;
    end
    pos_eol = (pos_col == COL_LAST);
    pos_eof = pos_eol && (pos_row == ROW_LAST);
    case (state)
      WAIT_SOF: process = accept && in_sof;
      ACTIVE: begin
        process = accept;
        sof_err = accept && in_sof && ((col != '0) || (row != '0));
      end
      default: process = 1'b0;
    endcase
    if (process) begin
      state_nxt = pos_eof ? WAIT_SOF : ACTIVE;
      if (pos_eol) begin
        col_nxt = '0;
        row_nxt = pos_eof ? '0 : pos_row + ROW_WIDTH'(1);
      end else begin
        col_nxt = pos_col + ADDR_WIDTH'(1);
        row_nxt = pos_row;
      end
    end
  end

  // Write and read the same column in the same cycle; the registered read returns the row above.
  assign mem_wr_en = process;
  assign mem_rd_en = process;
  assign mem_waddr = pos_col;
  assign mem_raddr = pos_col;
  assign mem_wdata = in_data;

  // FSM state and frame position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_SOF;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // ---- stage p1: output pair registers, held while downstream stalls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      cur_p1 <= '0;
      col_p1 <= '0;
      row_p1 <= '0;
      eol_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      err_p1 <= 1'b0;
      top_p1 <= 1'b1;
    end else if (process) begin
      vld_p1 <= 1'b1;
      cur_p1 <= in_data;
      col_p1 <= pos_col;
      row_p1 <= pos_row;
      eol_p1 <= pos_eol;
      eof_p1 <= pos_eof;
      err_p1 <= sof_err;
      top_p1 <= (pos_row == '0);
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end
  end

  // Row 0 has no valid line above; mask whatever the buffer holds.
  assign out_above = top_p1 ? '0 : mem_rdata;
  assign out_valid = vld_p1;
  assign out_cur   = cur_p1;
  assign out_col   = col_p1;
  assign out_row   = row_p1;
  assign out_eol   = eol_p1;
  assign out_eof   = eof_p1;
  assign err_sof   = err_p1;

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Testbench for line_delay_ctrl with a behavioural line-buffer memory and
// a frame-position reference model driven by directed and random stimulus.
module tb_line_delay_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_waddr;
  logic          mem_wr_en;
  logic [AW-1:0] mem_raddr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_cur;
  logic [DW-1:0] out_above;
  logic [AW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          out_eol;
  logic          out_eof;
  logic          err_sof;

  int n_checks = 0;
  int n_fail   = 0;

  line_delay_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ROW_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_wr_en(mem_wr_en),
    .mem_raddr(mem_raddr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_cur(out_cur),
    .out_above(out_above), .out_col(out_col), .out_row(out_row),
    .out_eol(out_eol), .out_eof(out_eof), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port memory: registered read returning pre-write contents
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (mem_wr_en) ram[mem_waddr] <= mem_wdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_rdata <= '0;
    else if (mem_rd_en) mem_rdata <= ram[mem_raddr];
  end

  // Reference model state: pixel index within the frame and last pixel per column
  bit            m_valid, m_eol, m_eof, m_err, m_sync;
  logic [DW-1:0] m_cur, m_above;
  int            m_col, m_row, m_pix;
  logic [DW-1:0] lastpix [W];
  bit            last_acc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_cur = '0; m_above = '0; m_col = 0; m_row = 0;
    m_eol = 0; m_eof = 0; m_err = 0; m_sync = 0; m_pix = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_cur",   32'(out_cur),   32'(m_cur));
    chk("out_above", 32'(out_above), 32'(m_above));
    chk("out_col",   32'(out_col),   32'(m_col));
    chk("out_row",   32'(out_row),   32'(m_row));
    chk("out_eol",   32'(out_eol),   32'(m_eol));
    chk("out_eof",   32'(out_eof),   32'(m_eof));
    chk("err_sof",   32'(err_sof),   32'(m_err));
  endtask

  // Compare the settled cycle, then advance the model to the next edge
  task automatic check_and_update();
    bit exp_ready, acc, proc;
    int idx, pc, pr;
    exp_ready = !m_valid || out_ready;
    acc  = in_valid && exp_ready;
    proc = acc && (m_sync || in_sof);
    idx  = in_sof ? 0 : m_pix;
    pc   = idx % W;
    pr   = idx / W;
    chk("in_ready",  32'(in_ready),  32'(exp_ready));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(proc));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(proc));
    if (proc) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(pc));
      chk("mem_raddr", 32'(mem_raddr), 32'(pc));
      chk("mem_wdata", 32'(mem_wdata), 32'(in_data));
    end
    check_outputs();
    last_acc = proc;
    if (proc) begin
      m_err   = in_sof && m_sync && (m_pix != 0);
      m_above = (pr == 0) ? '0 : lastpix[pc];
      lastpix[pc] = in_data;
      m_cur   = in_data;
      m_col   = pc;
      m_row   = pr;
      m_eol   = (pc == W - 1);
      m_eof   = (idx == W * H - 1);
      m_pix   = m_eof ? 0 : idx + 1;
      m_sync  = !m_eof;
      m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
      m_err   = 0;
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit s, input bit r);
    @(negedge clk);
    in_valid = v; in_data = d; in_sof = s; out_ready = r;
    #1;
    check_and_update();
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int first, input int n, input bit sof0);
    for (int i = first; i < first + n; i++)
      step(1'b1, base + DW'(i), sof0 && (i == first), 1'b1);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    in_valid = 0; in_sof = 0; out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_wr",   32'(mem_wr_en), 32'd0);
    chk("rst_mem_rd",   32'(mem_rd_en), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < W; i++) lastpix[i] = '0;
    model_reset();
    last_acc = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_wr",   32'(mem_wr_en), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single continuous frame, pixels 0..11
    send_frame(8'h00, 0, W * H, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Pre-SOF garbage is dropped
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + DW'(i), 1'b0, 1'b1);
    send_frame(8'h20, 0, W * H, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Backpressure mid-line: 5 stalled cycles, then resume from the stalled pixel
    send_frame(8'h30, 0, 5, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h35, 1'b0, 1'b0);
    send_frame(8'h30, 5, W * H - 5, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Unexpected SOF at (1,2), then the restarted frame runs to completion
    send_frame(8'h50, 0, 6, 1'b1);
    send_frame(8'h60, 0, W * H, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset while pixel (2,1) is pending, then a fresh frame
    send_frame(8'h70, 0, 10, 1'b1);
    async_reset_check();
    send_frame(8'h90, 0, W * H, 1'b1);

    // Back-to-back frames
    send_frame(8'hA0, 0, W * H, 1'b1);
    send_frame(8'hC0, 0, W * H, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Randomised valid/ready/sof traffic
    for (int i = 0; i < 500; i++)
      step(($urandom % 4) != 0, DW'($urandom), ($urandom % 16) == 0, ($urandom % 4) != 0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
